// File: rtl/ru_wb_arb.sv
// Register-unit writeback arbiter: round-robin between a single-cycle ALU (A) and a
// multicycle unit (B), with a one-cycle write stage and a busy scoreboard for B destinations.
module ru_wb_arb #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_data,
    output logic            b_ready,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    output logic            iss_ready,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            RUWr,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] DataWr,
    output logic [5:0]      busy_cnt,
    output logic            err
);

    typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_t;

    req_t            last;
    logic [31:1]     busy;
    logic [31:0]     busy_map;
    logic [31:0]     busy_nx;
    logic            grant_a;
    logic            grant_b;
    logic [4:0]      win_rd;
    logic [XLEN-1:0] win_data;
    logic            claim;
    logic            clear;

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {5'd0, v[i]};
        end
        return cnt;
    endfunction

    // x0 is never busy; the map gives a zero bit for index 0
    assign busy_map = {busy, 1'b0};

    always_comb begin
        grant_a  = a_valid && (!b_valid || last == REQ_B);
        grant_b  = b_valid && (!a_valid || last == REQ_A);
        win_rd   = grant_b ? b_rd : a_rd;
        win_data = grant_b ? b_data : a_data;
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // Claims are refused while any pending write to the same register is still in flight
    assign iss_ready = (iss_rd == 5'd0) ||
                       (!busy_map[iss_rd] &&
                        !(RUWr && rd == iss_rd) &&
                        !(grant_b && b_rd == iss_rd));

    assign claim = iss_valid && iss_ready && (iss_rd != 5'd0);
    assign clear = grant_b && (b_rd != 5'd0);

    assign rs1_busy = (rs1 != 5'd0) && (busy_map[rs1] || (RUWr && rd == rs1));
    assign rs2_busy = (rs2 != 5'd0) && (busy_map[rs2] || (RUWr && rd == rs2));

    always_comb begin
        busy_nx = busy_map;
        if (clear) busy_nx[b_rd] = 1'b0;
        if (claim) busy_nx[iss_rd] = 1'b1;
        busy_nx[0] = 1'b0;
    end

    // Scoreboard, round-robin pointer and error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= 6'd0;
            err      <= 1'b0;
            last     <= REQ_B;
        end else begin
            busy     <= busy_nx[31:1];
            busy_cnt <= popcount(busy_nx);
            if (clear && !busy_map[b_rd]) err <= 1'b1;
            if (grant_a)      last <= REQ_A;
            else if (grant_b) last <= REQ_B;
        end
    end

    // Write stage: one cycle after the grant; rd/DataWr hold when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RUWr   <= 1'b0;
            rd     <= 5'd0;
            DataWr <= '0;
        end else if (grant_a || grant_b) begin
            RUWr   <= (win_rd != 5'd0);
            rd     <= win_rd;
            DataWr <= win_data;
        end else begin
            RUWr   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ru_wb_arb.sv
// Self-checking bench for ru_wb_arb: directed scenarios plus randomized traffic
// compared against a behavioural scoreboard model.
module tb_ru_wb_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, iss_valid;
    logic [4:0]  a_rd, b_rd, iss_rd, rs1, rs2;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, iss_ready, rs1_busy, rs2_busy;
    logic        RUWr;
    logic [4:0]  rd;
    logic [31:0] DataWr;
    logic [5:0]  busy_cnt;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          m_busy[32];
    int          m_last;        // 0 = A, 1 = B
    bit          m_wr;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    bit          m_err;

    ru_wb_arb #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .RUWr(RUWr), .rd(rd), .DataWr(DataWr), .busy_cnt(busy_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic set_idle();
        a_valid = 0; a_rd = 0; a_data = 0;
        b_valid = 0; b_rd = 0; b_data = 0;
        iss_valid = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (RUWr !== 1'b0) begin errors++; $display("FAIL reset_ruwr: got %b expected 0", RUWr); end
        checks++; if (rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d expected 0", rd); end
        checks++; if (DataWr !== 32'd0) begin errors++; $display("FAIL reset_data: got %0h expected 0", DataWr); end
        checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_busy_cnt: got %0d expected 0", busy_cnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        rst = 1'b0;
        a_valid = 1; b_valid = 1; a_rd = 1; b_rd = 2;
        #2;
        checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0)
            begin errors++; $display("FAIL reset_first_grant: got a=%b b=%b expected a=1 b=0", a_ready, b_ready); end
        set_idle();
        do_reset();
    endtask

    task automatic test_single_write();
        do_reset();
        set_idle();
        a_valid = 1; a_rd = 5; a_data = 32'h1234;
        #2;
        checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0)
            begin errors++; $display("FAIL single_ready: got a=%b b=%b expected a=1 b=0", a_ready, b_ready); end
        tick();
        a_valid = 0;
        checks++; if (RUWr !== 1'b1 || rd !== 5'd5 || DataWr !== 32'h1234)
            begin errors++; $display("FAIL single_write: got ruwr=%b rd=%0d data=%0h expected 1 5 1234", RUWr, rd, DataWr); end
        tick();
        checks++; if (RUWr !== 1'b0) begin errors++; $display("FAIL single_ruwr_drop: got %b expected 0", RUWr); end
    endtask

    task automatic test_contention();
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        bit          exp_a;
        do_reset();
        set_idle();
        for (int i = 0; i < 3; i++) begin
            a_valid = 1; b_valid = 1;
            a_rd = 5'(10 + i); a_data = 32'hA000 + i;
            b_rd = 5'(20 + i); b_data = 32'hB000 + i;
            exp_a = (i != 1);
            exp_rd = exp_a ? a_rd : b_rd;
            exp_data = exp_a ? a_data : b_data;
            #2;
            checks++; if (a_ready !== exp_a || b_ready !== !exp_a)
                begin errors++; $display("FAIL contention_grant%0d: got a=%b b=%b expected a=%b b=%b", i, a_ready, b_ready, exp_a, !exp_a); end
            tick();
            checks++; if (RUWr !== 1'b1 || rd !== exp_rd || DataWr !== exp_data)
                begin errors++; $display("FAIL contention_write%0d: got %b %0d %0h expected 1 %0d %0h", i, RUWr, rd, DataWr, exp_rd, exp_data); end
        end
        set_idle();
    endtask

    task automatic test_scoreboard();
        do_reset();
        set_idle();
        iss_valid = 1; iss_rd = 7;
        #2;
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL sb_claim_ready: got %b expected 1", iss_ready); end
        tick();
        iss_valid = 0; rs1 = 7;
        #1;
        checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL sb_cnt_claim: got %0d expected 1", busy_cnt); end
        checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_rs1_busy: got %b expected 1", rs1_busy); end
        iss_valid = 1;
        #1;
        checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL sb_reclaim: got %b expected 0", iss_ready); end
        tick();
        iss_valid = 0;
        checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL sb_cnt_hold: got %0d expected 1", busy_cnt); end
        b_valid = 1; b_rd = 7; b_data = 32'hCAFE;
        #1;
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL sb_b_ready: got %b expected 1", b_ready); end
        tick();
        b_valid = 0;
        checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL sb_cnt_clear: got %0d expected 0", busy_cnt); end
        checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_rs1_wstage: got %b expected 1", rs1_busy); end
        checks++; if (RUWr !== 1'b1 || rd !== 5'd7 || DataWr !== 32'hCAFE || err !== 1'b0)
            begin errors++; $display("FAIL sb_b_write: got %b %0d %0h err=%b expected 1 7 cafe err=0", RUWr, rd, DataWr, err); end
        tick();
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_rs1_free: got %b expected 0", rs1_busy); end
        set_idle();
    endtask

    task automatic test_x0();
        do_reset();
        set_idle();
        a_valid = 1; a_rd = 0; a_data = 32'hFFFF;
        iss_valid = 1; iss_rd = 0; rs1 = 0;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL x0_a_ready: got %b expected 1", a_ready); end
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL x0_iss_ready: got %b expected 1", iss_ready); end
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL x0_rs1_busy: got %b expected 0", rs1_busy); end
        tick();
        checks++; if (RUWr !== 1'b0 || busy_cnt !== 6'd0)
            begin errors++; $display("FAIL x0_effect: got ruwr=%b cnt=%0d expected 0 0", RUWr, busy_cnt); end
        set_idle();
    endtask

    task automatic test_error();
        do_reset();
        set_idle();
        b_valid = 1; b_rd = 9; b_data = 32'h99;
        tick();
        b_valid = 0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", err); end
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
        a_valid = 1; a_rd = 9; a_data = 32'h42;
        tick();
        a_valid = 0;
        checks++; if (err !== 1'b1 || busy_cnt !== 6'd0 || RUWr !== 1'b1)
            begin errors++; $display("FAIL err_a_write: got err=%b cnt=%0d ruwr=%b expected 1 0 1", err, busy_cnt, RUWr); end
        set_idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_idle();
        iss_valid = 1; iss_rd = 3;
        tick();
        iss_valid = 0;
        b_valid = 1; b_rd = 3; b_data = 32'h333;
        #1;
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL mid_b_grant: got %b expected 1", b_ready); end
        rst = 1'b1;
        tick();
        b_valid = 0;
        checks++; if (RUWr !== 1'b0 || busy_cnt !== 6'd0 || err !== 1'b0)
            begin errors++; $display("FAIL mid_reset_state: got ruwr=%b cnt=%0d err=%b expected 0 0 0", RUWr, busy_cnt, err); end
        rst = 1'b0;
        a_valid = 1; b_valid = 1; a_rd = 4; b_rd = 3; iss_rd = 3;
        #1;
        checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0)
            begin errors++; $display("FAIL mid_last_b: got a=%b b=%b expected a=1 b=0", a_ready, b_ready); end
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL mid_iss_ready: got %b expected 1", iss_ready); end
        set_idle();
        tick();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
        m_last = 1; m_wr = 0; m_rd = 0; m_data = 0; m_err = 0;
    endtask

    task automatic test_random();
        int          winner;       // 0 none, 1 A, 2 B
        bit          e_iss, e_rs1, e_rs2;
        logic [4:0]  w_rd;
        logic [31:0] w_data;
        int          cnt;
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc % 150 == 149) begin
                set_idle();
                do_reset();
                model_reset();
            end
            a_valid = 1'($urandom_range(0, 1));
            b_valid = 1'($urandom_range(0, 1));
            iss_valid = 1'($urandom_range(0, 1));
            a_rd = 5'($urandom_range(0, 7));
            b_rd = 5'($urandom_range(0, 7));
            iss_rd = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            a_data = $urandom;
            b_data = $urandom;

            if (a_valid && b_valid) winner = (m_last == 0) ? 2 : 1;
            else if (a_valid)       winner = 1;
            else if (b_valid)       winner = 2;
            else                    winner = 0;
            e_iss = (iss_rd == 0) || !(m_busy[iss_rd] || (m_wr && m_rd == iss_rd) ||
                                       (winner == 2 && b_rd == iss_rd));
            e_rs1 = (rs1 != 0) && (m_busy[rs1] || (m_wr && m_rd == rs1));
            e_rs2 = (rs2 != 0) && (m_busy[rs2] || (m_wr && m_rd == rs2));
            #2;
            checks++; if (a_ready !== (winner == 1) || b_ready !== (winner == 2))
                begin errors++; $display("FAIL rnd_grant c%0d: got a=%b b=%b expected winner %0d", cyc, a_ready, b_ready, winner); end
            checks++; if (iss_ready !== e_iss)
                begin errors++; $display("FAIL rnd_iss_ready c%0d: got %b expected %b", cyc, iss_ready, e_iss); end
            checks++; if (rs1_busy !== e_rs1 || rs2_busy !== e_rs2)
                begin errors++; $display("FAIL rnd_rs_busy c%0d: got %b%b expected %b%b", cyc, rs1_busy, rs2_busy, e_rs1, e_rs2); end

            if (winner == 2 && b_rd != 0) begin
                if (!m_busy[b_rd]) m_err = 1;
                m_busy[b_rd] = 0;
            end
            if (iss_valid && e_iss && iss_rd != 0) m_busy[iss_rd] = 1;
            if (winner != 0) begin
                w_rd   = (winner == 1) ? a_rd : b_rd;
                w_data = (winner == 1) ? a_data : b_data;
                m_wr = (w_rd != 0); m_rd = w_rd; m_data = w_data;
                m_last = winner - 1;
            end else begin
                m_wr = 0;
            end
            cnt = 0;
            for (int i = 1; i < 32; i++) cnt += m_busy[i];

            tick();
            checks++; if (RUWr !== m_wr || rd !== m_rd || DataWr !== m_data)
                begin errors++; $display("FAIL rnd_write c%0d: got %b %0d %0h expected %b %0d %0h", cyc, RUWr, rd, DataWr, m_wr, m_rd, m_data); end
            checks++; if (busy_cnt !== 6'(cnt) || err !== m_err)
                begin errors++; $display("FAIL rnd_state c%0d: got cnt=%0d err=%b expected %0d %b", cyc, busy_cnt, err, cnt, m_err); end
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        test_reset();
        test_single_write();
        test_contention();
        test_scoreboard();
        test_x0();
        test_error();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
